// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg - definitions shared by the SPI master, its interface and its
// half-period tick generator.
//   spi_state_e : master FSM states
//   SPI_WORD_W  : default word width, matching the SPI slave packet size
//   cnt_width() : bits needed for a counter that must reach max_val
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_e;

    localparam int SPI_WORD_W = 15;

    // $clog2(max_val+1), never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if - control handshake and SPI pins of spi_master.
//   start/din       : transfer request and word to send (control side)
//   busy/done/dout  : frame status and last received word
//   sclk/mosi/ss    : SPI pins driven by the master
//   miso            : SPI pin driven by the slave
//   loopback        : only when SPI_MASTER_LOOPBACK_EN is defined
// Modports: master (the spi_master), slave (control logic and pin side).
// -----------------------------------------------------------------------------
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int M = SPI_WORD_W
);

    logic         start;
    logic [M-1:0] din;
    logic         busy;
    logic         done;
    logic [M-1:0] dout;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         ss;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic         loopback;

    modport master (
        input  start, din, miso, loopback,
        output busy, done, dout, sclk, mosi, ss
    );

    modport slave (
        output start, din, miso, loopback,
        input  busy, done, dout, sclk, mosi, ss
    );
`else
    modport master (
        input  start, din, miso,
        output busy, done, dout, sclk, mosi, ss
    );

    modport slave (
        output start, din, miso,
        input  busy, done, dout, sclk, mosi, ss
    );
`endif

endinterface

// File: rtl/spi_clk_tick.sv
// -----------------------------------------------------------------------------
// spi_clk_tick - SCLK half-period tick generator.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_restart : synchronous restart; holds the count at zero, no tick
//   o_tick    : one-cycle pulse every CLK_DIV cycles while not restarted
// The count wraps on its own tick, so each state of the master (which only
// leaves a non-IDLE state on a tick) starts with a fresh count.
// -----------------------------------------------------------------------------
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = !i_restart && (r_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master - mode 0 SPI master (SCLK idle low, MSB first, one M-bit word per
// SS-low frame). MOSI changes with SCLK falling, MISO is captured in the same
// clock edge that raises SCLK.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   bus (master)   : start/din in, busy/done/dout out, sclk/mosi/ss/miso pins
// Optional: SPI_MASTER_LOOPBACK_EN adds bus.loopback; when latched high with
// START the receive path samples the MOSI register instead of the MISO pin.
// Each non-IDLE state lasts CLK_DIV cycles, so SS is low for (2M+1)*CLK_DIV
// cycles and stays high for GAP plus one IDLE cycle between frames.
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int M       = SPI_WORD_W,
    parameter int CLK_DIV = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    spi_master_if.master bus
);

    localparam int            BW       = cnt_width(M);
    localparam logic [BW-1:0] BIT_LAST = BW'(M);

    spi_state_e    r_state, w_state_nxt;
    logic [M-1:0]  r_tx, w_tx_nxt;
    logic [M-1:0]  r_rx, w_rx_nxt;
    logic [M-1:0]  r_dout, w_dout_nxt;
    logic [BW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic          r_sclk, w_sclk_nxt;
    logic          r_mosi, w_mosi_nxt;
    logic          r_ss, w_ss_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          w_tick;
    logic          w_restart;
    logic          w_rx_bit;

    assign w_restart = (r_state == IDLE);

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    logic r_loopback, w_loopback_nxt;
    // r_mosi holds the bit currently on the wire, exactly what the slave sees.
    assign w_rx_bit = r_loopback ? r_mosi : bus.miso;
`else
    assign w_rx_bit = bus.miso;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable gets its hold value before the case statement, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_dout_nxt    = r_dout;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_ss_nxt      = r_ss;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        w_loopback_nxt = r_loopback;
`endif
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_tx_nxt      = bus.din;
                    w_rx_nxt      = '0;
                    w_bit_cnt_nxt = '0;
                    w_ss_nxt      = 1'b0;
                    w_mosi_nxt    = bus.din[M-1];
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
                    w_loopback_nxt = bus.loopback;
`endif
                end
            end
            // Entering HIGH is the SCLK rising edge: capture the rx bit here.
            SETUP, LOW: begin
                if (w_tick) begin
                    w_sclk_nxt    = 1'b1;
                    w_rx_nxt      = {r_rx[M-2:0], w_rx_bit};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_state_nxt   = HIGH;
                end
            end
            HIGH: begin
                if (w_tick) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_tx_nxt    = r_tx << 1;
                        w_mosi_nxt  = r_tx[M-2];
                        w_state_nxt = LOW;
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_ss_nxt    = 1'b1;
                    w_dout_nxt  = r_rx;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_dout    <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ss      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loopback <= 1'b0;
`endif
        end else begin
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_dout    <= w_dout_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_ss      <= w_ss_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loopback <= w_loopback_nxt;
`endif
        end
    end

    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.ss   = r_ss;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_dout;

endmodule
